// File: rtl/data_sram_resp_pkg.sv
// Shared types, constants and helpers for the data SRAM responder.
package data_sram_resp_pkg;

    localparam logic [1:0] SRAM_SIZE_B = 2'd0;
    localparam logic [1:0] SRAM_SIZE_H = 2'd1;
    localparam logic [1:0] SRAM_SIZE_W = 2'd2;

    localparam int RESP_DELAY_MAX  = 15;
    localparam int OUTSTANDING_MAX = 4;
    localparam int CNT_W           = 3;
    localparam int PTR_W           = 2;
    localparam int ENTRY_W         = 33;

    typedef struct packed {
        logic        is_write;
        logic [31:0] rdata;
    } resp_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } resp_state_e;

    function automatic logic [31:0] merge_wstrb(input logic [31:0] old_word,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) begin
                res[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/data_sram_resp_fifo.sv
// In-order response queue: DEPTH entries, pointers wrap modulo DEPTH.
module resp_fifo
    import data_sram_resp_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = ENTRY_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o
);

    // Storage is sized for the largest legal depth so the 2-bit pointers index it exactly.
    logic [WIDTH-1:0] mem_q [OUTSTANDING_MAX];
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Next pointer and occupancy values.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_i) begin
            wptr_d = ptr_inc(wptr_q);
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_i) begin
            rptr_d = ptr_inc(rptr_q);
        end else begin
            rptr_d = rptr_q;
        end
        if (push_i && !pop_i) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_i && pop_i) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= {PTR_W{1'b0}};
            rptr_q  <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage write.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM-like responder: word-addressed store, accept-time read/write,
// in-order responses after a programmable delay.
module data_sram_resp
    import data_sram_resp_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int OUTSTANDING = 2,
    parameter int RESP_DELAY  = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    input  logic        addr_stall
);

    logic [31:0]       mem_q [2**ADDR_W];
    logic [ADDR_W-1:0] idx_s;
    logic              accept_s;
    logic              pop_s;
    logic [CNT_W-1:0]  count_s;
    logic [CNT_W-1:0]  count_d;
    resp_entry_t       push_entry_s;
    resp_entry_t       head_s;
    resp_state_e       state_q, state_d;
    logic [3:0]        dcnt_q, dcnt_d;
    logic              data_ok_q;
    logic [31:0]       rdata_q;
    logic              unused_s;

    assign unused_s = ^{data_sram_size, data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

    assign idx_s             = data_sram_addr[ADDR_W+1:2];
    assign data_sram_addr_ok = ~addr_stall & (count_s < CNT_W'(OUTSTANDING));
    assign accept_s          = data_sram_req & data_sram_addr_ok;
    assign pop_s             = (state_q == ST_RESP);

    // Reads are sampled here, at acceptance, so a later write cannot change them.
    always_comb begin
        push_entry_s.is_write = data_sram_wr;
        if (data_sram_wr) begin
            push_entry_s.rdata = 32'h0;
        end else begin
            push_entry_s.rdata = mem_q[idx_s];
        end
    end

    resp_fifo #(
        .DEPTH (OUTSTANDING),
        .WIDTH (ENTRY_W)
    ) u_resp_fifo (
        .clk_i   (clk),
        .rst_ni  (resetn),
        .push_i  (accept_s),
        .pop_i   (pop_s),
        .wdata_i (push_entry_s),
        .rdata_o (head_s),
        .count_o (count_s)
    );

    // Byte-strobed commit of accepted writes; contents survive reset.
    always_ff @(posedge clk) begin
        if (accept_s && data_sram_wr) begin
            mem_q[idx_s] <= merge_wstrb(mem_q[idx_s], data_sram_wdata, data_sram_wstrb);
        end
    end

    // Delay counter and state follow the occupancy the queue will have next cycle.
    always_comb begin
        count_d = count_s;
        dcnt_d  = dcnt_q;
        state_d = state_q;
        if (accept_s && !pop_s) begin
            count_d = count_s + CNT_W'(1);
        end else if (!accept_s && pop_s) begin
            count_d = count_s - CNT_W'(1);
        end else begin
            count_d = count_s;
        end
        if (pop_s) begin
            dcnt_d = 4'd0;
        end else if ((count_s != {CNT_W{1'b0}}) && (dcnt_q < 4'(RESP_DELAY))) begin
            dcnt_d = dcnt_q + 4'd1;
        end else begin
            dcnt_d = dcnt_q;
        end
        if (count_d == {CNT_W{1'b0}}) begin
            state_d = ST_IDLE;
        end else if (dcnt_d == 4'(RESP_DELAY)) begin
            state_d = ST_RESP;
        end else begin
            state_d = ST_WAIT;
        end
    end

    // Response FSM with registered data_ok/rdata.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            dcnt_q    <= 4'd0;
            data_ok_q <= 1'b0;
            rdata_q   <= 32'h0;
        end else begin
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            data_ok_q <= pop_s;
            if (pop_s) begin
                rdata_q <= head_s.is_write ? 32'h0 : head_s.rdata;
            end else begin
                rdata_q <= rdata_q;
            end
        end
    end

    assign data_sram_data_ok = data_ok_q;
    assign data_sram_rdata   = rdata_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Self-checking bench for data_sram_resp against a cycle-time reference model.
module tb_data_sram_resp;

    localparam int AW     = 6;
    localparam int OUTS   = 2;
    localparam int DLY    = 3;
    localparam int NWORDS = 64;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct {
        int          t;
        logic [31:0] d;
    } pend_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req, wr, stall;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr, wdata;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;

    always #5 clk = ~clk;

    data_sram_resp #(
        .ADDR_W      (AW),
        .OUTSTANDING (OUTS),
        .RESP_DELAY  (DLY)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .data_sram_req     (req),
        .data_sram_wr      (wr),
        .data_sram_size    (size),
        .data_sram_wstrb   (wstrb),
        .data_sram_addr    (addr),
        .data_sram_wdata   (wdata),
        .data_sram_addr_ok (addr_ok),
        .data_sram_data_ok (data_ok),
        .data_sram_rdata   (rdata),
        .addr_stall        (stall)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          last_sched = 0;
    int          stall_left = 0;
    logic [31:0] mem_m [NWORDS];
    pend_t       pend[$];
    req_t        seq_q[$];
    logic [31:0] obs_q[$];
    int          obs_cyc[$];
    int          acc_cyc[$];
    logic [31:0] last_rdata = 32'h0;
    logic        exp_addr_ok, exp_data_ok, exp_accept;
    logic [31:0] exp_rdata;

    // Reference model: response time of each request is derived from when it
    // reaches the queue head; occupancy is the number of unresponded requests.
    task automatic eval();
        logic [AW-1:0] idx;
        logic [31:0]   d;
        int            tt;
        @(negedge clk);
        exp_data_ok = (pend.size() > 0) && (pend[0].t == cyc);
        if (exp_data_ok) begin
            last_rdata = pend[0].d;
            void'(pend.pop_front());
        end
        exp_rdata   = last_rdata;
        exp_addr_ok = !stall && (pend.size() < OUTS);
        exp_accept  = req && exp_addr_ok;
        if (exp_accept) begin
            idx = addr[AW+1:2];
            d   = wr ? 32'h0 : mem_m[idx];
            if (wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (wstrb[b]) mem_m[idx][8*b +: 8] = wdata[8*b +: 8];
                end
            end
            tt = ((cyc + 1 > last_sched) ? cyc + 1 : last_sched) + 1 + DLY;
            last_sched = tt;
            pend.push_back('{tt, d});
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic model_reset();
        pend.delete();
        last_rdata = 32'h0;
        last_sched = 0;
    endtask

    // Presents seq_q in order (holding each until accepted) and drains the queue.
    task automatic run_seq(input string name);
        obs_q.delete();
        obs_cyc.delete();
        acc_cyc.delete();
        for (int k = 0; k < 2000; k++) begin
            if (seq_q.size() == 0 && pend.size() == 0) break;
            stall = (stall_left > 0);
            if (stall_left > 0) stall_left--;
            if (seq_q.size() > 0) begin
                req = 1'b1; wr = seq_q[0].wr; addr = seq_q[0].addr;
                wdata = seq_q[0].wdata; wstrb = seq_q[0].wstrb;
            end else begin
                req = 1'b0;
            end
            eval();
            n_cmp++;
            if (addr_ok !== exp_addr_ok) begin
                n_bad++; $display("FAIL %s addr_ok cyc %0d: got %b want %b", name, cyc, addr_ok, exp_addr_ok);
            end
            n_cmp++;
            if (data_ok !== exp_data_ok) begin
                n_bad++; $display("FAIL %s data_ok cyc %0d: got %b want %b", name, cyc, data_ok, exp_data_ok);
            end
            n_cmp++;
            if (rdata !== exp_rdata) begin
                n_bad++; $display("FAIL %s rdata cyc %0d: got %h want %h", name, cyc, rdata, exp_rdata);
            end
            if (data_ok === 1'b1) begin
                obs_q.push_back(rdata);
                obs_cyc.push_back(cyc);
            end
            if (exp_accept) begin
                acc_cyc.push_back(cyc);
                void'(seq_q.pop_front());
            end
            adv();
        end
        req = 1'b0;
        stall = 1'b0;
        n_cmp++;
        if (seq_q.size() != 0 || pend.size() != 0) begin
            n_bad++; $display("FAIL %s timeout: %0d requests / %0d responses left, want 0", name, seq_q.size(), pend.size());
            seq_q.delete();
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; req = 1'b0; wr = 1'b0; stall = 1'b0; size = 2'd2;
        wstrb = 4'h0; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (data_ok !== 1'b0) begin n_bad++; $display("FAIL reset data_ok: got %b want 0", data_ok); end
        n_cmp++;
        if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset rdata: got %h want 0", rdata); end
        resetn = 1'b1;
        model_reset();
        eval();
        n_cmp++;
        if (addr_ok !== 1'b1) begin n_bad++; $display("FAIL reset addr_ok: got %b want 1", addr_ok); end
        adv();
    endtask

    task automatic test_fill();
        for (int w = 0; w < NWORDS; w++) seq_q.push_back('{1'b1, 32'(w * 4), $urandom, 4'hF});
        run_seq("fill");
        n_cmp++;
        if (obs_q.size() != NWORDS) begin n_bad++; $display("FAIL fill responses: got %0d want %0d", obs_q.size(), NWORDS); end
    endtask

    task automatic test_word_rw();
        seq_q.push_back('{1'b1, 32'h10, 32'hDEADBEEF, 4'hF});
        seq_q.push_back('{1'b0, 32'h10, 32'h0, 4'h0});
        run_seq("word_rw");
        n_cmp++;
        if (obs_q.size() != 2) begin
            n_bad++; $display("FAIL word_rw count: got %0d want 2", obs_q.size());
        end else begin
            n_cmp++;
            if (obs_q[0] !== 32'h0) begin n_bad++; $display("FAIL word_rw wresp: got %h want 0", obs_q[0]); end
            if (obs_q[1] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL word_rw rresp: got %h want deadbeef", obs_q[1]); end
        end
    endtask

    task automatic test_byte_write();
        seq_q.push_back('{1'b1, 32'h10, 32'h11223344, 4'hF});
        seq_q.push_back('{1'b1, 32'h13, 32'hABABABAB, 4'b1000});
        seq_q.push_back('{1'b1, 32'h10, 32'h55555555, 4'h0});
        seq_q.push_back('{1'b0, 32'h10, 32'h0, 4'h0});
        run_seq("byte_write");
        n_cmp++;
        if (obs_q.size() != 4 || obs_q[3] !== 32'hAB223344) begin
            n_bad++; $display("FAIL byte_write rdata: got %0d resp last %h want 4 resp last ab223344",
                              obs_q.size(), (obs_q.size() > 0) ? obs_q[obs_q.size()-1] : 32'h0);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) seq_q.push_back('{1'b0, 32'(32'h20 + 4 * i), 32'h0, 4'h0});
        run_seq("b2b");
        n_cmp++;
        if (acc_cyc.size() != 3 || obs_cyc.size() != 3) begin
            n_bad++; $display("FAIL b2b counts: got %0d acc %0d resp want 3 3", acc_cyc.size(), obs_cyc.size());
        end else begin
            n_cmp++;
            if (acc_cyc[2] != acc_cyc[0] + 5 || obs_cyc[0] != acc_cyc[0] + 5) begin
                n_bad++; $display("FAIL b2b timing: got third acc +%0d first resp +%0d want +5 +5",
                                  acc_cyc[2] - acc_cyc[0], obs_cyc[0] - acc_cyc[0]);
            end
            n_cmp++;
            if (obs_q[0] !== mem_m[8] || obs_q[1] !== mem_m[9] || obs_q[2] !== mem_m[10]) begin
                n_bad++; $display("FAIL b2b order: got %h %h %h want %h %h %h",
                                  obs_q[0], obs_q[1], obs_q[2], mem_m[8], mem_m[9], mem_m[10]);
            end
        end
    endtask

    task automatic test_read_then_write();
        seq_q.push_back('{1'b1, 32'h34, 32'h1, 4'hF});
        seq_q.push_back('{1'b0, 32'h34, 32'h0, 4'h0});
        seq_q.push_back('{1'b1, 32'h34, 32'h2, 4'hF});
        seq_q.push_back('{1'b0, 32'h34, 32'h0, 4'h0});
        run_seq("rd_then_wr");
        n_cmp++;
        if (obs_q.size() != 4 || obs_q[1] !== 32'h1 || obs_q[3] !== 32'h2) begin
            n_bad++; $display("FAIL rd_then_wr data: got %0d resp want 4 resp with old 1 then new 2", obs_q.size());
        end
    endtask

    task automatic test_stall();
        int start;
        start = cyc;
        stall_left = 4;
        seq_q.push_back('{1'b0, 32'h30, 32'h0, 4'h0});
        run_seq("stall");
        n_cmp++;
        if (acc_cyc.size() != 1 || acc_cyc[0] != start + 4) begin
            n_bad++; $display("FAIL stall accept: got %0d accepts first at +%0d want 1 at +4",
                              acc_cyc.size(), (acc_cyc.size() > 0) ? acc_cyc[0] - start : -1);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 500; k++) begin
            req   = (k < 400) && ($urandom_range(9, 0) < 7);
            wr    = $urandom_range(1, 0) == 1;
            addr  = $urandom;
            wdata = $urandom;
            wstrb = 4'($urandom);
            size  = 2'($urandom_range(2, 0));
            stall = $urandom_range(9, 0) < 2;
            eval();
            n_cmp++;
            if (addr_ok !== exp_addr_ok) begin n_bad++; $display("FAIL random addr_ok cyc %0d: got %b want %b", cyc, addr_ok, exp_addr_ok); end
            n_cmp++;
            if (data_ok !== exp_data_ok) begin n_bad++; $display("FAIL random data_ok cyc %0d: got %b want %b", cyc, data_ok, exp_data_ok); end
            n_cmp++;
            if (rdata !== exp_rdata) begin n_bad++; $display("FAIL random rdata cyc %0d: got %h want %h", cyc, rdata, exp_rdata); end
            adv();
        end
        req = 1'b0; stall = 1'b0; size = 2'd2;
    endtask

    task automatic test_reset_midop();
        int acc;
        acc = 0;
        req = 1'b1; wr = 1'b0; addr = 32'h40; wstrb = 4'h0;
        for (int k = 0; k < 20 && acc < 2; k++) begin
            eval();
            n_cmp++;
            if (addr_ok !== exp_addr_ok) begin n_bad++; $display("FAIL midrst addr_ok cyc %0d: got %b want %b", cyc, addr_ok, exp_addr_ok); end
            if (exp_accept) begin acc++; addr = 32'h44; end
            adv();
        end
        req = 1'b0;
        n_cmp++;
        if (pend.size() != 2) begin n_bad++; $display("FAIL midrst queued: got %0d want 2", pend.size()); end
        #1;
        resetn = 1'b0;
        #1;
        n_cmp++;
        if (data_ok !== 1'b0 || rdata !== 32'h0) begin
            n_bad++; $display("FAIL midrst outputs: got data_ok %b rdata %h want 0 0", data_ok, rdata);
        end
        model_reset();
        adv();
        adv();
        resetn = 1'b1;
        for (int k = 0; k < 12; k++) begin
            eval();
            n_cmp++;
            if (data_ok !== 1'b0 || addr_ok !== 1'b1) begin
                n_bad++; $display("FAIL midrst after release cyc %0d: got data_ok %b addr_ok %b want 0 1", cyc, data_ok, addr_ok);
            end
            adv();
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_word_rw();
        test_byte_write();
        test_back_to_back();
        test_read_then_write();
        test_stall();
        test_random();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
